// File: rtl/enc_pack_scheduler.sv
`default_nettype none
// ============================================================================
// enc_pack_scheduler : steps through the binder packs of one sample, one
// feature group per step, and hands each lane-masked group to the bundler.
// Rev 1.0
// ============================================================================
module enc_pack_scheduler #(
  parameter  int N_FEATURES = 617,
  parameter  int PACK_SIZE  = 10,
  parameter  int BIND_LAT   = 1,
  localparam int N_PACKS    = (N_FEATURES + PACK_SIZE - 1) / PACK_SIZE,
  localparam int SEL_W      = (N_PACKS > 1) ? $clog2(N_PACKS) : 1,
  localparam int FEAT_W     = $clog2(N_FEATURES + 1)
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 start_encoding_i,
  output logic                 pack_start_o,
  output logic [SEL_W-1:0]     pack_sel_o,
  output logic [FEAT_W-1:0]    feat_base_o,
  output logic [PACK_SIZE-1:0] lane_mask_o,
  output logic                 pack_valid_o,
  input  logic                 bundle_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int                LAT_W     = 4;
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(BIND_LAT - 1);
  localparam logic [SEL_W-1:0]  LAST_PACK = SEL_W'(N_PACKS - 1);
  localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);
  localparam logic [FEAT_W-1:0] PACK_STEP = FEAT_W'(PACK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  pack_idx_q;
  logic [FEAT_W-1:0] feat_base_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic              pack_start_q;
  logic              pack_valid_q;
  logic              busy_q;
  logic              done_q;

  // Output flags are set on the transition into the state that owns them,
  // so each one is a plain flop rather than a decode of state_q.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= S_IDLE;
      pack_idx_q   <= '0;
      feat_base_q  <= '0;
      lat_cnt_q    <= '0;
      pack_start_q <= 1'b0;
      pack_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pack_start_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_encoding_i) begin
            state_q      <= S_ISSUE;
            pack_idx_q   <= '0;
            feat_base_q  <= '0;
            pack_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_ISSUE: begin
          lat_cnt_q <= LAT_INIT;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt_q == '0) begin
            state_q      <= S_PRESENT;
            pack_valid_q <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_PRESENT: begin
          if (bundle_ready_i) begin
            pack_valid_q <= 1'b0;
            if (pack_idx_q == LAST_PACK) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              pack_idx_q   <= pack_idx_q + SEL_ONE;
              feat_base_q  <= feat_base_q + PACK_STEP;
              pack_start_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          pack_idx_q  <= '0;
          feat_base_q <= '0;
        end
        default: begin
          state_q      <= S_IDLE;
          pack_idx_q   <= '0;
          feat_base_q  <= '0;
          lat_cnt_q    <= '0;
          pack_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Only the final group can run past N_FEATURES, so one compare per lane
  // yields all-ones for every other group.
  for (genvar i = 0; i < PACK_SIZE; i++) begin : g_lane
    assign lane_mask_o[i] = (32'(feat_base_q) + 32'(i)) < 32'(N_FEATURES);
  end

  assign pack_start_o = pack_start_q;
  assign pack_sel_o   = pack_idx_q;
  assign feat_base_o  = feat_base_q;
  assign pack_valid_o = pack_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire
